// File: rtl/ladybird_hazard_unit_pkg.sv
// Shared types and defaults for the ladybird issue/hazard controller.
package ladybird_config;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } hazard_state_e;

   localparam int unsigned DEF_MAX_INFLIGHT = 4;
   localparam int unsigned DEF_CNT_W        = 3;

   // A source operand conflicts when it is read, is not x0 and has a pending writer.
   function automatic logic src_hazard(input logic en, input logic [4:0] addr,
                                       input logic [31:0] busy);
      return en & (addr != 5'd0) & busy[addr];
   endfunction

endpackage

// File: rtl/ladybird_hazard_unit_if.sv
// Issue and commit handshake bundle between the core pipeline and the hazard unit.
interface ladybird_hazard_unit_if;

   logic       iss_valid;
   logic [4:0] iss_rs1;
   logic [4:0] iss_rs2;
   logic       iss_rs1_en;
   logic       iss_rs2_en;
   logic [4:0] iss_rd;
   logic       iss_wb_en;
   logic       iss_ready;

   logic       cmt_valid;
   logic [4:0] cmt_rd;
   logic       cmt_wb_en;
   logic       cmt_redirect;
   logic       cmt_trap;

   modport master (
      output iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en, iss_rd, iss_wb_en,
      input  iss_ready,
      output cmt_valid, cmt_rd, cmt_wb_en, cmt_redirect, cmt_trap
   );

   modport slave (
      input  iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en, iss_rd, iss_wb_en,
      output iss_ready,
      input  cmt_valid, cmt_rd, cmt_wb_en, cmt_redirect, cmt_trap
   );

endinterface

// File: rtl/ladybird_hazard_unit_scoreboard.sv
// Per-register pending-writeback counters; busy[r] flags a nonzero count.
module ladybird_scoreboard #(
   parameter int unsigned CNT_W = 3
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        clear,
   input  logic        inc_en,
   input  logic [4:0]  inc_rd,
   input  logic        dec_en,
   input  logic [4:0]  dec_rd,
   output logic [31:0] busy
);

   logic [CNT_W-1:0] pend [32];
   logic [31:0]      inc_vec;
   logic [31:0]      dec_vec;

   // x0 is masked out of both decoders so it can never become pending.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (inc_en) inc_vec[inc_rd] = 1'b1;
      if (dec_en) dec_vec[dec_rd] = 1'b1;
      inc_vec[0] = 1'b0;
      dec_vec[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!nrst || clear) begin
         for (int unsigned r = 0; r < 32; r++) pend[r] <= '0;
      end else begin
         pend[0] <= '0;
         for (int unsigned r = 1; r < 32; r++) begin
            case ({inc_vec[r], dec_vec[r]})
               2'b10:   pend[r] <= pend[r] + CNT_W'(1);
               2'b01:   if (pend[r] != '0) pend[r] <= pend[r] - CNT_W'(1);
               default: pend[r] <= pend[r];
            endcase
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int unsigned r = 0; r < 32; r++) busy[r] = |pend[r];
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (nrst && dec_en && dec_rd != 5'd0)
         assert (pend[dec_rd] != '0)
         else $error("scoreboard: writeback retired for x%0d with nothing pending", dec_rd);
   end
`endif

endmodule

// File: rtl/ladybird_hazard_unit.sv
// In-order issue controller: RAW/in-flight stall, commit flush, run/drain/halt FSM.
// Optional perf counters (stall_cycles, flush_count) under LADYBIRD_HAZARD_PERF_EN.
module ladybird_hazard_unit
   import ladybird_config::*;
#(
   parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 start,
   input  logic                 halt_req,
   input  logic                 resume,
   ladybird_hazard_unit_if.slave bus,
   output logic                 flush,
   output logic                 fetch_en,
   output logic [1:0]           state,
   output logic [CNT_W-1:0]     inflight,
   output logic [31:0]          busy
`ifdef LADYBIRD_HAZARD_PERF_EN
   ,
   output logic [31:0]          stall_cycles,
   output logic [31:0]          flush_count
`endif
);

   if (MAX_INFLIGHT > (2 ** CNT_W) - 1) begin : g_bad_cfg
      $error("CNT_W too narrow to hold MAX_INFLIGHT");
   end

   hazard_state_e    state_q, state_d;
   logic [CNT_W-1:0] inflight_q;
   logic             hazard;
   logic             room;
   logic             ready_c;
   logic             flush_c;
   logic             fire;

   always_ff @(posedge clk) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = RUN;
         RUN: begin
            if (bus.cmt_valid && bus.cmt_trap) state_d = HALT;
            else if (halt_req)                 state_d = DRAIN;
         end
         DRAIN: if (inflight_q == '0 && !bus.cmt_valid) state_d = HALT;
         HALT:  if (resume) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hazard  = src_hazard(bus.iss_rs1_en, bus.iss_rs1, busy) |
                src_hazard(bus.iss_rs2_en, bus.iss_rs2, busy);
      room    = 32'(inflight_q) < MAX_INFLIGHT;
      flush_c = nrst & bus.cmt_valid & (bus.cmt_redirect | bus.cmt_trap) &
                ((state_q == RUN) | (state_q == DRAIN));
      ready_c = nrst & (state_q == RUN) & ~hazard & room & ~flush_c;
      fire    = bus.iss_valid & ready_c;
   end

   assign bus.iss_ready = ready_c;
   assign flush         = flush_c;
   assign fetch_en      = (state_q == RUN);
   assign state         = state_q;
   assign inflight      = inflight_q;

   // Flush wins over any same-cycle issue or retire: everything older has committed.
   always_ff @(posedge clk) begin
      if (!nrst || flush_c) begin
         inflight_q <= '0;
      end else if (fire && !bus.cmt_valid) begin
         inflight_q <= inflight_q + CNT_W'(1);
      end else if (!fire && bus.cmt_valid && inflight_q != '0) begin
         inflight_q <= inflight_q - CNT_W'(1);
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (nrst && bus.cmt_valid && !fire)
         assert (inflight_q != '0)
         else $error("hazard unit: commit with no instruction in flight");
   end
`endif

   ladybird_scoreboard #(
      .CNT_W (CNT_W)
   ) u_scoreboard (
      .clk    (clk),
      .nrst   (nrst),
      .clear  (flush_c),
      .inc_en (fire & bus.iss_wb_en),
      .inc_rd (bus.iss_rd),
      .dec_en (bus.cmt_valid & bus.cmt_wb_en),
      .dec_rd (bus.cmt_rd),
      .busy   (busy)
   );

`ifdef LADYBIRD_HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (!nrst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (state_q == RUN && bus.iss_valid && !ready_c) stall_cycles <= stall_cycles + 32'd1;
         if (flush_c) flush_count <= flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ladybird_hazard_unit.sv
// Directed self-checking bench for ladybird_hazard_unit.
module tb_ladybird_hazard_unit;

   logic        clk = 1'b0;
   logic        nrst, start, halt_req, resume;
   logic        flush, fetch_en;
   logic [1:0]  state;
   logic [2:0]  inflight;
   logic [31:0] busy;
`ifdef LADYBIRD_HAZARD_PERF_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   int unsigned passed = 0;
   int unsigned total  = 0;

   ladybird_hazard_unit_if bus ();

   ladybird_hazard_unit #(
      .MAX_INFLIGHT (4),
      .CNT_W        (3)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .start    (start),
      .halt_req (halt_req),
      .resume   (resume),
      .bus      (bus),
      .flush    (flush),
      .fetch_en (fetch_en),
      .state    (state),
      .inflight (inflight),
      .busy     (busy)
`ifdef LADYBIRD_HAZARD_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_iss(input logic e1, input logic [4:0] r1, input logic e2,
                          input logic [4:0] r2, input logic [4:0] rd, input logic wb);
      bus.iss_valid  = 1'b1;
      bus.iss_rs1_en = e1;
      bus.iss_rs1    = r1;
      bus.iss_rs2_en = e2;
      bus.iss_rs2    = r2;
      bus.iss_rd     = rd;
      bus.iss_wb_en  = wb;
   endtask

   task automatic set_cmt(input logic [4:0] rd, input logic wb);
      bus.cmt_valid    = 1'b1;
      bus.cmt_rd       = rd;
      bus.cmt_wb_en    = wb;
      bus.cmt_redirect = 1'b0;
      bus.cmt_trap     = 1'b0;
   endtask

   initial begin
      nrst = 1'b0; start = 1'b0; halt_req = 1'b0; resume = 1'b0;
      bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0;
      bus.iss_rs1_en = 1'b0; bus.iss_rs2_en = 1'b0; bus.iss_rd = '0; bus.iss_wb_en = 1'b0;
      bus.cmt_valid = 1'b0; bus.cmt_rd = '0; bus.cmt_wb_en = 1'b0;
      bus.cmt_redirect = 1'b0; bus.cmt_trap = 1'b0;
      tick(); tick();

      chk("rst_state", 32'(state), 32'd0);
      chk("rst_fetch_en", 32'(fetch_en), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      chk("rst_busy", busy, 32'd0);
      bus.iss_valid = 1'b1; #1;
      chk("rst_ready", 32'(bus.iss_ready), 32'd0);
      bus.iss_valid = 1'b0;

      nrst = 1'b1; start = 1'b1; tick(); start = 1'b0;
      chk("start_state", 32'(state), 32'd1);
      chk("start_fetch_en", 32'(fetch_en), 32'd1);

      // independent producer of x5
      set_iss(1'b1, 5'd1, 1'b1, 5'd2, 5'd5, 1'b1); #1;
      chk("indep_ready", 32'(bus.iss_ready), 32'd1);
      tick();
      chk("busy_x5", busy, 32'h0000_0020);
      chk("inflight_1", 32'(inflight), 32'd1);

      // consumer of x5 stalls, including the cycle x5 retires
      set_iss(1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0); #1;
      chk("raw_stall", 32'(bus.iss_ready), 32'd0);
      tick();
      chk("raw_stall_hold", 32'(bus.iss_ready), 32'd0);
      set_cmt(5'd5, 1'b1); #1;
      chk("raw_retire_cycle", 32'(bus.iss_ready), 32'd0);
      tick(); bus.cmt_valid = 1'b0; #1;
      chk("raw_busy_clear", busy, 32'd0);
      chk("raw_inflight_0", 32'(inflight), 32'd0);
      chk("raw_ready_after", 32'(bus.iss_ready), 32'd1);
      tick(); bus.iss_valid = 1'b0;
      chk("consumer_inflight", 32'(inflight), 32'd1);
      set_cmt(5'd0, 1'b0); tick(); bus.cmt_valid = 1'b0;

      // writes to x0 never mark it pending
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1); #1;
      chk("x0_ready", 32'(bus.iss_ready), 32'd1);
      tick();
      chk("x0_busy", busy, 32'd0);
      set_iss(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0); #1;
      chk("x0_consumer_ready", 32'(bus.iss_ready), 32'd1);
      tick(); bus.iss_valid = 1'b0;
      chk("x0_inflight_2", 32'(inflight), 32'd2);
      set_cmt(5'd0, 1'b1); tick(); tick(); bus.cmt_valid = 1'b0;
      chk("x0_inflight_0", 32'(inflight), 32'd0);

      // in-flight limit
      for (int i = 0; i < 4; i++) begin
         set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'(10 + i), 1'b1);
         tick();
      end
      chk("full_inflight", 32'(inflight), 32'd4);
      chk("full_busy", busy, 32'h0000_3C00);
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'd14, 1'b1); #1;
      chk("full_ready", 32'(bus.iss_ready), 32'd0);
      set_cmt(5'd10, 1'b1); #1;
      chk("full_ready_cmt", 32'(bus.iss_ready), 32'd0);
      tick(); bus.cmt_valid = 1'b0; #1;
      chk("full_inflight_3", 32'(inflight), 32'd3);
      chk("full_ready_room", 32'(bus.iss_ready), 32'd1);
      tick(); bus.iss_valid = 1'b0;
      chk("full_refill", 32'(inflight), 32'd4);
      chk("full_busy2", busy, 32'h0000_7800);
      for (int i = 11; i < 15; i++) begin
         set_cmt(5'(i), 1'b1);
         tick();
      end
      bus.cmt_valid = 1'b0;
      chk("full_drained", 32'(inflight), 32'd0);
      chk("full_busy_clr", busy, 32'd0);

      // redirect flush
      for (int i = 7; i < 10; i++) begin
         set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'(i), 1'b1);
         tick();
      end
      bus.iss_valid = 1'b0;
      chk("fl_inflight", 32'(inflight), 32'd3);
      chk("fl_busy", busy, 32'h0000_0380);
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'd20, 1'b1);
      set_cmt(5'd7, 1'b1); bus.cmt_redirect = 1'b1; #1;
      chk("fl_flush", 32'(flush), 32'd1);
      chk("fl_ready", 32'(bus.iss_ready), 32'd0);
      tick();
      bus.iss_valid = 1'b0; bus.cmt_valid = 1'b0; bus.cmt_redirect = 1'b0; #1;
      chk("fl_inflight_clr", 32'(inflight), 32'd0);
      chk("fl_busy_clr", busy, 32'd0);
      chk("fl_flush_off", 32'(flush), 32'd0);
`ifdef LADYBIRD_HAZARD_PERF_EN
      chk("fl_count", flush_count, 32'd1);
`endif
      set_iss(1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 1'b0); #1;
      chk("fl_reissue", 32'(bus.iss_ready), 32'd1);
      bus.iss_valid = 1'b0;

      // drain then halt
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 1'b1); tick();
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'd4, 1'b1); tick();
      bus.iss_valid = 1'b0;
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      chk("drain_state", 32'(state), 32'd2);
      chk("drain_fetch_en", 32'(fetch_en), 32'd0);
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0); #1;
      chk("drain_ready", 32'(bus.iss_ready), 32'd0);
      bus.iss_valid = 1'b0;
      set_cmt(5'd3, 1'b1); tick();
      set_cmt(5'd4, 1'b1); tick();
      chk("drain_wait", 32'(state), 32'd2);
      bus.cmt_valid = 1'b0; tick();
      chk("halt_state", 32'(state), 32'd3);
      resume = 1'b1; tick(); resume = 1'b0;
      chk("resume_state", 32'(state), 32'd1);

      // trap beats a simultaneous halt request
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0); tick();
      bus.iss_valid = 1'b0;
      set_cmt(5'd0, 1'b0); bus.cmt_trap = 1'b1; halt_req = 1'b1; #1;
      chk("trap_flush", 32'(flush), 32'd1);
      tick();
      bus.cmt_valid = 1'b0; bus.cmt_trap = 1'b0; halt_req = 1'b0;
      chk("trap_state", 32'(state), 32'd3);
      chk("trap_inflight", 32'(inflight), 32'd0);

      // reset mid-operation
      resume = 1'b1; tick(); resume = 1'b0;
      set_iss(1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 1'b1); tick();
      chk("pre_rst_busy", busy, 32'h0000_0020);
      nrst = 1'b0; tick();
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_busy", busy, 32'd0);
      chk("mid_rst_inflight", 32'(inflight), 32'd0);
      chk("mid_rst_ready", 32'(bus.iss_ready), 32'd0);
      bus.iss_valid = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
